mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
Parametrised load/store unit that replaces the single-cycle memory control path. It decodes LDR/STR, drives a req/ack memory bus with wait states, byte/half/word access with byte enables, sign/zero extension and a timeout. It muxes the PC onto the address bus when idle and selects the load result or ALU result for write-back. It sits between execute and the data/instruction memory and stalls the pipeline while an access is in flight.

Parameters:
ADDR_W, 16, byte-address bus width (>= PC_W, >= 2)
PC_W, 8, program counter width; zero-extended onto mem_addr when idle
TIMEOUT, 12, max cycles in ACCESS awaiting mem_ack before err (1..255)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
pc  in  PC_W  fetch address
start  in  1  instruction valid this cycle
op_code  in  4  LDR=4'b1101, STR=4'b1110, others non-memory
size  in  2  00 byte, 01 half, 10 word, 11 reserved
ld_unsigned  in  1  1 zero-extend, 0 sign-extend sub-word loads
src1  in  32  effective byte address (low ADDR_W bits used)
src2  in  32  store data (low bits for sub-word)
alu_result  in  32  non-memory write-back value
mem_rdata  in  32  memory read data
mem_ack  in  1  memory completes access this cycle
mem_addr  out  ADDR_W  address bus
mem_wdata  out  32  store data, lane-replicated
mem_be  out  4  byte enables
mem_rw  out  1  1 read, 0 write
mem_req  out  1  access request
wb_data  out  32  write-back value
busy  out  1  stall pipeline
done  out  1  one-cycle pulse, memory op complete
err  out  1  one-cycle pulse with done: misaligned, reserved size or timeout

Behaviour:
- Reset (async): state IDLE, mem_req=0, mem_rw=1, mem_be=0, mem_wdata=0, busy=0, done=0, err=0, load register=0, timeout counter=0.
- States: IDLE, ACCESS, COMPLETE.
- IDLE: mem_addr = zero-extended pc, mem_rw=1, mem_req=0. wb_data = alu_result combinationally. start with a non-memory op_code has no state effect.
- IDLE + start + LDR/STR: latch address, size, ld_unsigned, op. Alignment rule: half needs addr[0]=0, word needs addr[1:0]=0, size 11 is illegal. If illegal, go to COMPLETE with err flag set and issue no request. Otherwise go to ACCESS. busy rises the cycle after start.
- ACCESS: mem_req=1, mem_addr=latched address, mem_rw=1 for LDR and 0 for STR. mem_be: byte 4'b0001<<a[1:0], half 4'b0011<<a[1:0], word 4'b1111. mem_wdata: byte replicated x4, half replicated x2, word as-is. Counter increments each cycle.
- mem_ack in the same cycle as a counter reading of TIMEOUT-1: ack wins.
- ACCESS + mem_ack: for LDR, extract the lane by a[1:0], extend per ld_unsigned and register it; go to COMPLETE.
- ACCESS timeout: no ack after TIMEOUT cycles in ACCESS, so go to COMPLETE with err. The load register becomes 0. mem_req drops.
- COMPLETE: done=1, err=flag, busy=1. wb_data = load register for LDR, alu_result for STR. Then go to IDLE and clear counter and flag. start in COMPLETE is ignored; the pipeline is stalled by busy.
- busy = (state != IDLE). mem_req is low in IDLE and COMPLETE.
- Latency: aligned access with a zero-wait ack is start in cycle 0, req in cycle 1, done in cycle 2.
- Reset mid-ACCESS: immediate return to IDLE, request dropped, no done.
- Unused outputs during a load: mem_wdata and mem_be hold their last values. mem_be is driven (reads still state lanes).

Decomposition:
- Shared package mau_pkg holds: OP_LDR/OP_STR codes, SZ_BYTE/SZ_HALF/SZ_WORD/SZ_RSVD, state enum, the mem_rw encoding.
- Sub-module load_align (combinational): inputs rdata, a[1:0], size, ld_unsigned; output 32-bit extended value. This isolates the lane/extension logic for unit test.

Test Plan:
- Idle fetch: pc=8'hA5, no start -> mem_addr=16'h00A5, mem_req=0, wb_data tracks alu_result=32'h1234, busy=0.
- Word LDR with zero wait: src1=16'h0010, mem_rdata=32'hDEADBEEF, ack in the first ACCESS cycle -> mem_be=4'hF, mem_rw=1, done at cycle 2, wb_data=32'hDEADBEEF, err=0.
- Byte LDR, signed and unsigned: addr 16'h0013, rdata=32'h80FF_0000. Signed gives wb_data=32'hFFFF_FF80. Unsigned gives 32'h0000_0080. mem_be=4'b1000 in both.
- Half STR with 3 wait states: addr 16'h0022, src2=32'h0000_BEEF -> mem_wdata=32'hBEEF_BEEF, mem_be=4'b1100, mem_rw=0. mem_req is held 4 cycles, then done.
- Misaligned word at 16'h0021, and size=11 -> no mem_req ever, done=err=1 one cycle after start.
- Timeout: no ack with TIMEOUT=12 -> mem_req high exactly 12 cycles, then done=err=1, LDR wb_data=0. Assert rst during ACCESS in a second run -> all outputs at reset values asynchronously, and no done pulse.

Source files
------------

// File: rtl/mau_pkg.sv
// rtl/mau_pkg.sv - shared opcodes, access sizes, FSM states and bus encodings for mem_access_unit
package mau_pkg;

    localparam logic [3:0] OP_LDR = 4'b1101;
    localparam logic [3:0] OP_STR = 4'b1110;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_ACCESS   = 2'd1;
    localparam logic [1:0] ST_COMPLETE = 2'd2;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    // Legal means a defined size whose natural alignment the address satisfies.
    function automatic logic access_legal(input logic [1:0] sz, input logic [1:0] a);
        case (sz)
            SZ_BYTE: access_legal = 1'b1;
            SZ_HALF: access_legal = (a[0] == 1'b0);
            SZ_WORD: access_legal = (a == 2'b00);
            default: access_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// rtl/mem_access_unit_load_align.sv - selects the load lane and sign/zero extends it
module load_align
    import mau_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  a,
    input  logic [1:0]  size,
    input  logic        ld_unsigned,
    output logic [31:0] value
);

    logic [31:0] shifted;

    always_comb begin
        shifted = rdata >> {a, 3'b000};
        case (size)
            SZ_BYTE: value = {{24{~ld_unsigned & shifted[7]}}, shifted[7:0]};
            SZ_HALF: value = {{16{~ld_unsigned & shifted[15]}}, shifted[15:0]};
            default: value = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store unit: req/ack bus with wait states, byte enables and timeout
module mem_access_unit
    import mau_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int PC_W    = 8,
    parameter int TIMEOUT = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PC_W-1:0]   pc,
    input  logic              start,
    input  logic [3:0]        op_code,
    input  logic [1:0]        size,
    input  logic              ld_unsigned,
    input  logic [31:0]       src1,
    input  logic [31:0]       src2,
    input  logic [31:0]       alu_result,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    output logic              mem_rw,
    output logic              mem_req,
    output logic [31:0]       wb_data,
    output logic              busy,
    output logic              done,
    output logic              err
);

    logic [1:0]        state;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic              is_ld_q;
    logic              err_q;
    logic [7:0]        cnt;
    logic [31:0]       ld_q;
    logic [31:0]       ld_value;

    logic mem_op;
    logic legal;

    assign mem_op = (op_code == OP_LDR) || (op_code == OP_STR);
    assign legal  = access_legal(size, src1[1:0]);

    load_align u_load_align (
        .rdata       (mem_rdata),
        .a           (addr_q[1:0]),
        .size        (size_q),
        .ld_unsigned (uns_q),
        .value       (ld_value)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            addr_q    <= '0;
            size_q    <= SZ_BYTE;
            uns_q     <= 1'b0;
            is_ld_q   <= 1'b0;
            err_q     <= 1'b0;
            cnt       <= '0;
            ld_q      <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start && mem_op) begin
                        addr_q  <= src1[ADDR_W-1:0];
                        size_q  <= size;
                        uns_q   <= ld_unsigned;
                        is_ld_q <= (op_code == OP_LDR);
                        cnt     <= '0;
                        if (legal) begin
                            state <= ST_ACCESS;
                            case (size)
                                SZ_BYTE: mem_be <= 4'b0001 << src1[1:0];
                                SZ_HALF: mem_be <= 4'b0011 << src1[1:0];
                                default: mem_be <= 4'b1111;
                            endcase
                            // Loads leave the write data bus untouched.
                            if (op_code == OP_STR) begin
                                case (size)
                                    SZ_BYTE: mem_wdata <= {4{src2[7:0]}};
                                    SZ_HALF: mem_wdata <= {2{src2[15:0]}};
                                    default: mem_wdata <= src2;
                                endcase
                            end
                        end else begin
                            state <= ST_COMPLETE;
                            err_q <= 1'b1;
                            ld_q  <= '0;
                        end
                    end
                end
                ST_ACCESS: begin
                    // An ack on the last allowed cycle still completes cleanly.
                    if (mem_ack) begin
                        state <= ST_COMPLETE;
                        if (is_ld_q) ld_q <= ld_value;
                    end else if (cnt == 8'(TIMEOUT - 1)) begin
                        state <= ST_COMPLETE;
                        err_q <= 1'b1;
                        ld_q  <= '0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                ST_COMPLETE: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                    err_q <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign mem_req  = (state == ST_ACCESS);
    assign mem_rw   = (state == ST_ACCESS) ? (is_ld_q ? RW_READ : RW_WRITE) : RW_READ;
    assign mem_addr = (state == ST_IDLE) ? ADDR_W'(pc) : addr_q;
    assign busy     = (state != ST_IDLE);
    assign done     = (state == ST_COMPLETE);
    assign err      = done & err_q;
    assign wb_data  = (state == ST_COMPLETE && is_ld_q) ? ld_q : alu_result;

endmodule
